// File: rtl/tpram_fifo_pkg.sv
// Shared defaults and types for the TPRAM-backed streaming FIFO controller.
package tpram_fifo_pkg;

    localparam int DW_DEF    = 16;
    localparam int AW_DEF    = 8;
    localparam int DEPTH_DEF = 1 << AW_DEF;

    // Output buffer occupancy: 0, 1 or 2 entries.
    typedef logic [1:0] buf_cnt_t;

endpackage

// File: rtl/tpram_fifo_ctrl_out_skid_buf.sv
// Two-entry output buffer that absorbs RAM read returns and feeds the downstream stream.
module out_skid_buf
    import tpram_fifo_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output buf_cnt_t      count,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    buf_cnt_t      cnt_q, cnt_d;

    // The caller's credit rule guarantees no push into a full buffer and no pop when empty.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = push_data;
                end else begin
                    tail_d = push_data;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = push_data;
                end else begin
                    head_d = push_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign count     = cnt_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = head_q;

endmodule

// File: rtl/tpram_fifo_ctrl.sv
// Streaming FIFO controller around an external two-port RAM with a 2-entry output buffer.
// Handshakes: a word moves when valid && ready are both high at a rising edge; valid never waits on ready.
module tpram_fifo_ctrl
    import tpram_fifo_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   ram_count,
    output logic          ram_wea,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_data_a,
    output logic          ram_enb,
    output logic [AW-1:0] ram_addrb,
    input  logic [DW-1:0] ram_data_b
);

    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          inflight_q, inflight_d;

    logic     wr;
    logic     rd;
    logic     pop;
    logic     skid_valid;
    buf_cnt_t buf_cnt;
    logic [2:0] occ;

    always_comb begin
        in_ready = !rst && (count_q != FULL);
        wr       = in_valid && in_ready;
        pop      = skid_valid && out_ready;
        // Words already owed to the buffer after this cycle's pop; a new read needs a free slot.
        occ      = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
        rd       = !rst && (count_q != '0) && (occ < 3'd2);
    end

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        inflight_d = rd;
        if (wr) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({wr, rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

    // A read issued last cycle returns now; reset clears inflight_q so a stale return is dropped.
    out_skid_buf #(.DW(DW)) u_out_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (ram_data_b),
        .pop       (pop),
        .count     (buf_cnt),
        .out_valid (skid_valid),
        .out_data  (out_data)
    );

    assign out_valid  = skid_valid;
    assign ram_count  = count_q;
    assign ram_wea    = wr;
    assign ram_addra  = rst ? '0 : wptr_q;
    assign ram_data_a = in_data;
    assign ram_enb    = rd;
    assign ram_addrb  = rst ? '0 : rptr_q;

endmodule

// File: tb/tb_tpram_fifo_ctrl.sv
// Directed bench for tpram_fifo_ctrl with a behavioural TPRAM and an in-order scoreboard.
module tb_tpram_fifo_ctrl;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   ram_count;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_data_a;
    logic          ram_enb;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_data_b;

    int n_checks = 0;
    int n_errors = 0;
    int n_popped = 0;
    logic mon_en = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] vals [4];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    tpram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .ram_count  (ram_count),
        .ram_wea    (ram_wea),
        .ram_addra  (ram_addra),
        .ram_data_a (ram_data_a),
        .ram_enb    (ram_enb),
        .ram_addrb  (ram_addrb),
        .ram_data_b (ram_data_b)
    );

    // Behavioural TPRAM: registered read port.
    initial ram_data_b = '0;
    always @(posedge clk) begin
        if (ram_wea) mem[ram_addra] <= ram_data_a;
        if (ram_enb) ram_data_b <= mem[ram_addrb];
    end

    // ---------------- driver / check tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [DW-1:0] exp_w;
        if (mon_en) begin
            if (in_valid && in_ready) exp_q.push_back(in_data);
            if (out_valid && out_ready) begin
                n_popped++;
                chk("pop_with_empty_queue", 32'(exp_q.size() == 0), 32'd0);
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    chk("out_data_order", 32'(out_data), 32'(exp_w));
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int acc;
        int sent;
        int base;
        vals = '{16'd9, 16'd2, 16'd7, 16'd7};
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        #1 chk("in_ready_during_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_ram_count", 32'(ram_count), 32'd0);
        chk("rst_ram_wea", 32'(ram_wea), 32'd0);
        chk("rst_ram_enb", 32'(ram_enb), 32'd0);
        chk("rst_ram_addra", 32'(ram_addra), 32'd0);
        chk("rst_ram_addrb", 32'(ram_addrb), 32'd0);
        tick();

        // Single word, 3-cycle latency
        mon_en = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'd9;
        #1;
        chk("w0_wea", 32'(ram_wea), 32'd1);
        chk("w0_addra", 32'(ram_addra), 32'd0);
        chk("w0_data_a", 32'(ram_data_a), 32'd9);
        tick();
        in_valid = 1'b0;
        #1;
        chk("c1_count", 32'(ram_count), 32'd1);
        chk("c1_enb", 32'(ram_enb), 32'd1);
        chk("c1_addrb", 32'(ram_addrb), 32'd0);
        chk("c1_out_valid", 32'(out_valid), 32'd0);
        tick();
        #1;
        chk("c2_count", 32'(ram_count), 32'd0);
        chk("c2_out_valid", 32'(out_valid), 32'd0);
        tick();
        #1;
        chk("c3_out_valid", 32'(out_valid), 32'd1);
        chk("c3_out_data", 32'(out_data), 32'd9);
        tick();
        #1 chk("c4_out_valid", 32'(out_valid), 32'd0);

        // Four back-to-back words at full throughput
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 4);
            if (c < 4) in_data = vals[c];
            #1;
            if (c >= 3 && c <= 6) begin
                chk("stream_out_valid", 32'(out_valid), 32'd1);
                chk("stream_out_data", 32'(out_data), 32'(vals[c-3]));
            end else begin
                chk("stream_idle_valid", 32'(out_valid), 32'd0);
            end
            tick();
        end

        // Fill with downstream stalled
        out_ready = 1'b0; acc = 0;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1; in_data = 16'(acc);
            #1;
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("fill_accepted", 32'(acc), 32'd258);
        chk("fill_ram_count", 32'(ram_count), 32'd256);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_out_valid", 32'(out_valid), 32'd1);
        chk("fill_head", 32'(out_data), 32'd0);

        // One pop at full frees exactly one RAM slot
        in_valid = 1'b1; in_data = 16'd258; out_ready = 1'b1;
        #1;
        chk("full_pop_in_ready", 32'(in_ready), 32'd0);
        chk("full_pop_enb", 32'(ram_enb), 32'd1);
        tick();
        out_ready = 1'b0;
        #1;
        chk("after_pop_count", 32'(ram_count), 32'd255);
        chk("after_pop_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_data = 16'd259;
        #1;
        chk("refill_count", 32'(ram_count), 32'd256);
        chk("refill_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        tick();

        // Drain in order
        out_ready = 1'b1; base = n_popped;
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) tick();
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_popped", 32'(n_popped - base), 32'd258);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_count", 32'(ram_count), 32'd0);
        chk("wrap_addra", 32'(ram_addra), 32'd8);
        chk("wrap_addrb", 32'(ram_addrb), 32'd8);

        // Long stream with random backpressure, pointers wrap
        sent = 0; base = n_popped;
        for (int c = 0; c < 5000 && sent < 600; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = 16'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("rand_sent", 32'(sent), 32'd600);
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) tick();
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("rand_popped", 32'(n_popped - base), 32'd600);

        // Mid-operation reset with 50 stored words and a read in flight
        out_ready = 1'b0;
        for (int i = 0; i < 52; i++) begin
            in_valid = 1'b1; in_data = 16'(16'h0100 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        #1;
        chk("pre_rst_count", 32'(ram_count), 32'd50);
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
        #1;
        chk("pre_rst_enb", 32'(ram_enb), 32'd1);
        chk("pre_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        #1 chk("rst_cycle_count", 32'(ram_count), 32'd50);
        tick();
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_count", 32'(ram_count), 32'd0);
        chk("post_rst_out_data", 32'(out_data), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk("post_rst_valid_seq", 32'(out_valid), 32'(c == 3));
            if (c == 3) chk("post_rst_data", 32'(out_data), 32'h0000BEEF);
            tick();
        end
        chk("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
